seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles each digit is displayed before the scan advances; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-004 The block SHALL have port wr_en, input, 1, digit-write strobe, sampled every cycle.
REQ-005 The block SHALL have port wr_addr, input, 2, digit index written (0 = rightmost).
REQ-006 The block SHALL have port wr_data, input, 4, BCD value written.
REQ-007 The block SHALL have port lz_en, input, 1, leading-zero suppression enable, level-sensitive.
REQ-008 The block SHALL have port bcd, output, 4, BCD code of the currently scanned digit, to the shared 7-segment decoder.
REQ-009 The block SHALL have port dig_sel, output, 4, one-hot active-high enable of the currently scanned digit.
REQ-010 The block SHALL have port blank, output, 1, high when the scanned digit is suppressed.
REQ-011 The block SHALL have port wr_err, output, 1, registered one-cycle pulse flagging a rejected write.
REQ-012 The block SHALL have port frame, output, 1, one-cycle pulse marking the last cycle of a full 4-digit scan.

Function
REQ-013 The block SHALL hold four 4-bit digit registers d[0..3].
REQ-014 A write with wr_en=1 and wr_data<=9 SHALL update d[wr_addr] on that clock edge.
REQ-015 A write with wr_data in 10..15 SHALL leave all d[] unchanged and SHALL set wr_err=1 for exactly the next cycle.
REQ-016 wr_err SHALL be 0 in every cycle not following a rejected write; back-to-back rejected writes SHALL hold wr_err high for each following cycle.
REQ-017 A prescaler pcnt SHALL count 0..DIV-1 and wrap to 0; with DIV=1 it SHALL stay 0 and the scan SHALL advance every cycle.
REQ-018 Scan index idx SHALL increment modulo 4 (3 wraps to 0) on each edge where pcnt==DIV-1; otherwise it holds.
REQ-019 bcd SHALL equal d[idx] combinationally from registered state, so a write lands on bcd one cycle after the write strobe when wr_addr==idx.
REQ-020 A write and a scan advance on the same edge SHALL both take effect; bcd SHALL then show the new d[new idx].
REQ-021 dig_sel SHALL equal one-hot(idx) when blank=0, and SHALL be 4'b0000 when blank=1.
REQ-022 With lz_en=1, digit i in 1..3 SHALL be blanked iff d[i]..d[3] are all 0; digit 0 SHALL never be blanked.
REQ-023 With lz_en=0, blank SHALL be 0 at all times.
REQ-024 bcd SHALL carry d[idx] even while blank=1.
REQ-025 frame SHALL be 1 exactly in cycles where idx==3 and pcnt==DIV-1, giving one pulse per 4*DIV cycles.
REQ-026 Writes SHALL not disturb pcnt or idx.

Reset
REQ-027 With reset=1 at an edge, d[0..3], pcnt, idx and wr_err SHALL all become 0, regardless of wr_en.
REQ-028 After reset, outputs SHALL be bcd=0, dig_sel=0001, blank=0 and frame=0 (DIV>1); with DIV=1, frame SHALL be 0 because idx=0.
REQ-029 A reset asserted mid-scan SHALL restart the scan at idx=0 and pcnt=0 on the next edge, with no frame pulse in that cycle.

Verification (DIV=4)
REQ-030 Reset, then idle 16 cycles -> dig_sel sequence 0001,0010,0100,1000, 4 cycles each; frame high only in cycle 16; bcd=0 throughout.
REQ-031 Write d0=3, d1=7, d2=9, d3=1, lz_en=0 -> bcd shows 3,7,9,1 in digit order; blank never set.
REQ-032 Write wr_addr=2, wr_data=4'hC after d2=9 -> wr_err pulses 1 cycle later for 1 cycle; d2 stays 9.
REQ-033 d3=0, d2=0, d1=5, d0=0, lz_en=1 -> blank=1 and dig_sel=0000 during idx 2,3; digits 0 and 1 shown; all d=0 -> only digit 0 unblanked.
REQ-034 Write d1=6 on the exact edge where idx advances 0->1 -> bcd=6 in the next cycle with dig_sel=0010.
REQ-035 Assert reset when idx=2, pcnt=1 -> next cycle idx=0, dig_sel=0001, all d=0, wr_err=0, frame=0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with BCD digit store and leading-zero blanking.
// Latency: a write reaches bcd one cycle after the strobe; wr_err follows a rejected write by one cycle.
// Backpressure: none; writes are accepted every cycle, and out-of-range BCD values are dropped and flagged.
module seg7_scan_ctrl #(
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       lz_en,
   output logic [3:0] bcd,
   output logic [3:0] dig_sel,
   output logic       blank,
   output logic       wr_err,
   output logic       frame
);

   // Prescaler width; at least one bit so DIV=1 still has a (constant-zero) counter.
   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   logic [3:0]    d [4];
   logic [PW-1:0] pcnt;
   logic [1:0]    idx;
   logic          adv;

   // Scan advances on the last prescaler cycle of each digit slot.
   assign adv = (pcnt == PMAX);

   // Prescaler and scan index; independent of writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt <= '0;
         idx  <= 2'd0;
      end else if (adv) begin
         pcnt <= '0;
         idx  <= idx + 2'd1;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   // Digit store: only legal BCD values are written; anything else raises wr_err next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) d[i] <= 4'd0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && (wr_data > 4'd9);
         if (wr_en && (wr_data <= 4'd9)) d[wr_addr] <= wr_data;
      end
   end

   // Leading-zero blanking: digit i blanks only if it and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      blank = 1'b0;
      if (lz_en) begin
         case (idx)
            2'd1:    blank = ((d[1] | d[2] | d[3]) == 4'd0);
            2'd2:    blank = ((d[2] | d[3]) == 4'd0);
            2'd3:    blank = (d[3] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
   end

   // Digit outputs: bcd always carries the stored value, enable is dropped while blanked.
   always_comb begin
      bcd     = d[idx];
      dig_sel = blank ? 4'b0000 : (4'b0001 << idx);
      frame   = (idx == 2'd3) && adv;
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIV=4): directed scenarios followed by random traffic.
// Reference model tracks elapsed cycles since reset and derives scan position arithmetically.
// Outputs are sampled on the falling clock edge.
module tb_seg7_scan_ctrl;
   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset, wr_en, lz_en;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
   logic [3:0] bcd, dig_sel;
   logic       blank, wr_err, frame;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int         t;          // cycles since reset, modulo one full frame
   logic [3:0] m_d [4];
   logic       m_err;

   seg7_scan_ctrl #(.DIV(DIV)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .lz_en(lz_en), .bcd(bcd), .dig_sel(dig_sel), .blank(blank), .wr_err(wr_err), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   // Compare every output against values derived from the model.
   task automatic check_all();
      int ix, pc;
      logic eb;
      logic [3:0] esel;
      ix = (t / DIV) % 4;
      pc = t % DIV;
      eb = lz_en && (ix != 0);
      for (int j = ix; j < 4; j++) if (m_d[j] != 4'd0) eb = 1'b0;
      esel = eb ? 4'd0 : 4'(1 << ix);
      chk("bcd",     bcd,          m_d[ix]);
      chk("dig_sel", dig_sel,      esel);
      chk("blank",   {3'b0, blank},  {3'b0, eb});
      chk("frame",   {3'b0, frame},  {3'b0, (ix == 3) && (pc == DIV - 1)});
      chk("wr_err",  {3'b0, wr_err}, {3'b0, m_err});
   endtask

   // One clock cycle with the given inputs, then model update and full check.
   task automatic cyc(input logic r, input logic we, input logic [1:0] a, input logic [3:0] dt);
      reset = r; wr_en = we; wr_addr = a; wr_data = dt;
      @(posedge clk);
      if (r) begin
         t = 0; m_err = 1'b0;
         for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      end else begin
         t = (t + 1) % (4 * DIV);
         m_err = we && (dt > 4'd9);
         if (we && dt <= 4'd9) m_d[a] = dt;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 4'd0);
   endtask

   initial begin
      int fr_cnt;
      int r_rst;
      logic [3:0] r_dat;
      reset = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; lz_en = 1'b0;
      t = 0; m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'd0;
      @(negedge clk);

      // Reset (with a write pending, which must be ignored) and the post-reset state.
      cyc(1'b1, 1'b1, 2'd0, 4'd5);
      chk("rst_dig_sel", dig_sel, 4'b0001);
      chk("rst_bcd", bcd, 4'd0);

      // Idle scan: one frame pulse in the first 16 cycles, in the last one.
      fr_cnt = int'(frame);
      for (int i = 0; i < 15; i++) begin
         idle(1);
         fr_cnt += int'(frame);
      end
      chk("frame_count", 4'(fr_cnt), 4'd1);
      chk("frame_last", {3'b0, frame}, 4'd1);

      // Load 3,7,9,1 with blanking off and scan through a full frame.
      cyc(1'b0, 1'b1, 2'd0, 4'd3);
      cyc(1'b0, 1'b1, 2'd1, 4'd7);
      cyc(1'b0, 1'b1, 2'd2, 4'd9);
      cyc(1'b0, 1'b1, 2'd3, 4'd1);
      idle(16);

      // Rejected write: pulse next cycle only, store untouched.
      cyc(1'b0, 1'b1, 2'd2, 4'hC);
      chk("wr_err_pulse", {3'b0, wr_err}, 4'd1);
      idle(1);
      chk("wr_err_clear", {3'b0, wr_err}, 4'd0);
      // Back-to-back rejects hold wr_err high.
      cyc(1'b0, 1'b1, 2'd0, 4'hF);
      cyc(1'b0, 1'b1, 2'd1, 4'hA);
      chk("wr_err_b2b", {3'b0, wr_err}, 4'd1);
      idle(16);

      // Leading-zero suppression: 0,0,5,0 then all zeros.
      lz_en = 1'b1;
      cyc(1'b0, 1'b1, 2'd3, 4'd0);
      cyc(1'b0, 1'b1, 2'd2, 4'd0);
      cyc(1'b0, 1'b1, 2'd1, 4'd5);
      cyc(1'b0, 1'b1, 2'd0, 4'd0);
      idle(16);
      cyc(1'b0, 1'b1, 2'd1, 4'd0);
      idle(16);
      lz_en = 1'b0;

      // Write d1=6 on the edge where idx advances 0->1.
      while (t != DIV - 1) idle(1);
      cyc(1'b0, 1'b1, 2'd1, 4'd6);
      chk("wr_on_adv_bcd", bcd, 4'd6);
      chk("wr_on_adv_sel", dig_sel, 4'b0010);

      // Reset mid-scan at idx=2, pcnt=1.
      cyc(1'b0, 1'b1, 2'd3, 4'd8);
      while (t != 2 * DIV + 1) idle(1);
      cyc(1'b1, 1'b1, 2'd2, 4'hE);
      chk("mid_rst_sel", dig_sel, 4'b0001);
      chk("mid_rst_frame", {3'b0, frame}, 4'd0);
      chk("mid_rst_err", {3'b0, wr_err}, 4'd0);
      idle(16);

      // Random traffic, biased toward zeros to exercise blanking.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom_range(0, 1));
         r_rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
         r_dat = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         cyc(r_rst != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r_dat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
